// File: rtl/dds_command_encoder.sv
// Host-side DDS command encoder: compares a requested setpoint with a shadow of the
// controller registers and emits the minimal ordered list of 64-bit command words.
module dds_command_encoder #(
  parameter logic [63:0] TS_STEP = 64'd1
) (
  input  logic        CLK100MHZ,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_force,
  input  logic [47:0] req_freq,
  input  logic [13:0] req_amp,
  input  logic [13:0] req_phase,
  input  logic [13:0] req_amp_offset,
  input  logic [59:0] req_time_offset,
  input  logic [63:0] req_timestamp,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [63:0] cmd_word,
  output logic [63:0] cmd_timestamp,
  output logic        req_done,
  output logic [2:0]  req_nwords
);

  typedef enum logic [1:0] {IDLE, PLAN, EMIT} state_t;
  state_t state;

  // Latched request
  logic        l_force;
  logic [47:0] l_freq;
  logic [13:0] l_amp;
  logic [13:0] l_phase;
  logic [13:0] l_amp_offset;
  logic [59:0] l_time_offset;
  logic [63:0] l_timestamp;

  // Shadow of controller registers
  logic [47:0] s_freq;
  logic [13:0] s_amp;
  logic [13:0] s_phase;
  logic [13:0] s_amp_offset;
  logic [59:0] s_time_offset;

  // Planned word list
  logic [63:0] wlist [4];
  logic [2:0]  wcount;
  logic [1:0]  widx;

  logic [63:0] plan_w [4];
  logic [2:0]  plan_cnt;

  logic [63:0] w_time_offset;
  logic [63:0] w_amp_offset;
  logic [63:0] w_fap_hi;
  logic [63:0] w_fap_lo;
  logic [63:0] w_freq;
  logic [63:0] w_amp_freq;
  logic [63:0] w_phase_freq;

  assign w_time_offset = {4'b0100, l_time_offset};
  assign w_amp_offset  = {4'b0101, 46'b0, l_amp_offset};
  assign w_fap_hi      = {4'b0000, l_amp, l_phase, l_freq[47:16]};
  assign w_fap_lo      = {4'b1111, l_amp, l_phase, l_freq[31:0]};
  assign w_freq        = {4'b0001, 12'b0, l_freq};
  assign w_amp_freq    = {4'b0010, l_amp, l_freq[47:2]};
  assign w_phase_freq  = {4'b0011, l_phase, l_freq[47:2]};

  logic to_diff, ao_diff, fap_diff;
  logic freq_lo16_same, freq_hi16_same, freq_lo2_same, amp_same, phase_same;

  assign to_diff        = (l_time_offset != s_time_offset);
  assign ao_diff        = (l_amp_offset != s_amp_offset);
  assign amp_same       = (l_amp == s_amp);
  assign phase_same     = (l_phase == s_phase);
  assign freq_lo16_same = (l_freq[15:0] == s_freq[15:0]);
  assign freq_hi16_same = (l_freq[47:32] == s_freq[47:32]);
  assign freq_lo2_same  = (l_freq[1:0] == s_freq[1:0]);
  assign fap_diff       = (l_freq != s_freq) || !amp_same || !phase_same;

  // Words are appended in priority order; plan_cnt doubles as the write pointer.
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) plan_w[i] = '0;
    plan_cnt = '0;
    if (l_force) begin
      plan_w[0] = w_time_offset;
      plan_w[1] = w_amp_offset;
      plan_w[2] = w_freq;
      plan_w[3] = w_fap_hi;
      plan_cnt  = 3'd4;
    end else begin
      if (to_diff) begin
        plan_w[plan_cnt[1:0]] = w_time_offset;
        plan_cnt = plan_cnt + 3'd1;
      end
      if (ao_diff) begin
        plan_w[plan_cnt[1:0]] = w_amp_offset;
        plan_cnt = plan_cnt + 3'd1;
      end
      if (fap_diff) begin
        if (freq_lo16_same) begin
          plan_w[plan_cnt[1:0]] = w_fap_hi;
          plan_cnt = plan_cnt + 3'd1;
        end else if (freq_hi16_same) begin
          plan_w[plan_cnt[1:0]] = w_fap_lo;
          plan_cnt = plan_cnt + 3'd1;
        end else if (amp_same && phase_same) begin
          plan_w[plan_cnt[1:0]] = w_freq;
          plan_cnt = plan_cnt + 3'd1;
        end else if (freq_lo2_same && phase_same) begin
          plan_w[plan_cnt[1:0]] = w_amp_freq;
          plan_cnt = plan_cnt + 3'd1;
        end else if (freq_lo2_same && amp_same) begin
          plan_w[plan_cnt[1:0]] = w_phase_freq;
          plan_cnt = plan_cnt + 3'd1;
        end else begin
          plan_w[plan_cnt[1:0]] = w_freq;
          plan_cnt = plan_cnt + 3'd1;
          plan_w[plan_cnt[1:0]] = w_fap_hi;
          plan_cnt = plan_cnt + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state         <= IDLE;
      req_ready     <= 1'b1;
      cmd_valid     <= 1'b0;
      cmd_word      <= '0;
      cmd_timestamp <= '0;
      req_done      <= 1'b0;
      req_nwords    <= '0;
      l_force       <= 1'b0;
      l_freq        <= '0;
      l_amp         <= '0;
      l_phase       <= '0;
      l_amp_offset  <= '0;
      l_time_offset <= '0;
      l_timestamp   <= '0;
      s_freq        <= '0;
      s_amp         <= '0;
      s_phase       <= '0;
      s_amp_offset  <= '0;
      s_time_offset <= '0;
      for (int unsigned i = 0; i < 4; i++) wlist[i] <= '0;
      wcount        <= '0;
      widx          <= '0;
    end else begin
      req_done <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            l_force       <= req_force;
            l_freq        <= req_freq;
            l_amp         <= req_amp;
            l_phase       <= req_phase;
            l_amp_offset  <= req_amp_offset;
            l_time_offset <= req_time_offset;
            l_timestamp   <= req_timestamp;
            req_ready     <= 1'b0;
            state         <= PLAN;
          end
        end
        PLAN: begin
          for (int unsigned i = 0; i < 4; i++) wlist[i] <= plan_w[i];
          wcount <= plan_cnt;
          widx   <= '0;
          if (plan_cnt == 3'd0) begin
            req_done   <= 1'b1;
            req_nwords <= '0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end else begin
            cmd_valid     <= 1'b1;
            cmd_word      <= plan_w[0];
            cmd_timestamp <= l_timestamp;
            state         <= EMIT;
          end
        end
        EMIT: begin
          if (cmd_valid && cmd_ready) begin
            if ({1'b0, widx} == wcount - 3'd1) begin
              // Shadow is committed only once the whole list has been accepted.
              s_freq        <= l_freq;
              s_amp         <= l_amp;
              s_phase       <= l_phase;
              s_amp_offset  <= l_amp_offset;
              s_time_offset <= l_time_offset;
              cmd_valid     <= 1'b0;
              req_done      <= 1'b1;
              req_nwords    <= wcount;
              req_ready     <= 1'b1;
              state         <= IDLE;
            end else begin
              widx          <= widx + 2'd1;
              cmd_word      <= wlist[widx + 2'd1];
              cmd_timestamp <= cmd_timestamp + TS_STEP;
            end
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          cmd_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dds_command_encoder.sv
// Self-checking bench for dds_command_encoder: directed scenarios plus randomized
// setpoint sequences checked against a rule-level model of the command format.
module tb_dds_command_encoder;

  localparam logic [63:0] TS = 64'd1;

  logic        CLK100MHZ = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_force = 1'b0;
  logic [47:0] req_freq = '0;
  logic [13:0] req_amp = '0;
  logic [13:0] req_phase = '0;
  logic [13:0] req_amp_offset = '0;
  logic [59:0] req_time_offset = '0;
  logic [63:0] req_timestamp = '0;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [63:0] cmd_word;
  logic [63:0] cmd_timestamp;
  logic        req_done;
  logic [2:0]  req_nwords;

  int checks = 0;
  int errors = 0;

  always #5 CLK100MHZ = ~CLK100MHZ;

  dds_command_encoder #(.TS_STEP(TS)) dut (
    .CLK100MHZ(CLK100MHZ), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_force(req_force),
    .req_freq(req_freq), .req_amp(req_amp), .req_phase(req_phase),
    .req_amp_offset(req_amp_offset), .req_time_offset(req_time_offset),
    .req_timestamp(req_timestamp),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_word(cmd_word),
    .cmd_timestamp(cmd_timestamp), .req_done(req_done), .req_nwords(req_nwords)
  );

  typedef struct {
    logic [47:0] freq;
    logic [13:0] amp;
    logic [13:0] phase;
    logic [13:0] ao;
    logic [59:0] to;
    logic [63:0] ts;
    logic        frc;
  } req_t;

  req_t sh;               // model of controller registers
  logic [63:0] exp_q[$];  // expected words for the current request

  task automatic clear_shadow();
    sh.freq = '0; sh.amp = '0; sh.phase = '0; sh.ao = '0; sh.to = '0;
    sh.ts = '0; sh.frc = 1'b0;
  endtask

  // Encoding rules of the command format, applied to the model shadow.
  task automatic model_plan(input req_t r);
    exp_q.delete();
    if (r.frc) begin
      exp_q.push_back({4'h4, r.to});
      exp_q.push_back({4'h5, 46'b0, r.ao});
      exp_q.push_back({4'h1, 12'b0, r.freq});
      exp_q.push_back({4'h0, r.amp, r.phase, r.freq[47:16]});
    end else begin
      if (r.to != sh.to) exp_q.push_back({4'h4, r.to});
      if (r.ao != sh.ao) exp_q.push_back({4'h5, 46'b0, r.ao});
      if (r.freq != sh.freq || r.amp != sh.amp || r.phase != sh.phase) begin
        if (r.freq[15:0] == sh.freq[15:0])
          exp_q.push_back({4'h0, r.amp, r.phase, r.freq[47:16]});
        else if (r.freq[47:32] == sh.freq[47:32])
          exp_q.push_back({4'hF, r.amp, r.phase, r.freq[31:0]});
        else if (r.amp == sh.amp && r.phase == sh.phase)
          exp_q.push_back({4'h1, 12'b0, r.freq});
        else if (r.freq[1:0] == sh.freq[1:0] && r.phase == sh.phase)
          exp_q.push_back({4'h2, r.amp, r.freq[47:2]});
        else if (r.freq[1:0] == sh.freq[1:0] && r.amp == sh.amp)
          exp_q.push_back({4'h3, r.phase, r.freq[47:2]});
        else begin
          exp_q.push_back({4'h1, 12'b0, r.freq});
          exp_q.push_back({4'h0, r.amp, r.phase, r.freq[47:16]});
        end
      end
    end
  endtask

  task automatic drive_req(input req_t r);
    req_freq = r.freq; req_amp = r.amp; req_phase = r.phase;
    req_amp_offset = r.ao; req_time_offset = r.to; req_timestamp = r.ts;
    req_force = r.frc;
  endtask

  task automatic scramble_inputs();
    req_freq = {16'($urandom), $urandom};
    req_amp = 14'($urandom); req_phase = 14'($urandom); req_amp_offset = 14'($urandom);
    req_time_offset = {28'($urandom), $urandom};
    req_timestamp = {$urandom, $urandom};
    req_force = 1'($urandom);
  endtask

  // mode 0: always ready; 1: random ready; 2: 5-cycle stall on the second word
  task automatic run_req(input req_t r, input int mode, input string tag);
    int got = 0, stall = 0, first_cyc = -1;
    logic prev_hold = 1'b0, stalled_once = 1'b0, done = 1'b0, rdy;
    logic [63:0] pw = '0, pt = '0, ets;
    model_plan(r);
    @(posedge CLK100MHZ); #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL %s req_ready_idle: got %b want 1", tag, req_ready);
    end
    drive_req(r);
    req_valid = 1'b1;
    cmd_ready = 1'b0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      @(posedge CLK100MHZ); #1;
      if (cyc == 0) begin
        req_valid = 1'b0;
        scramble_inputs();
        checks++;
        if (req_ready !== 1'b0) begin
          errors++; $display("FAIL %s req_ready_busy: got %b want 0", tag, req_ready);
        end
      end
      if (req_done === 1'b1) begin
        done = 1'b1;
        checks++;
        if (req_nwords !== 3'(exp_q.size()) || got != exp_q.size() || cmd_valid !== 1'b0) begin
          errors++;
          $display("FAIL %s done: nwords %0d words %0d cmd_valid %b, want %0d words, cmd_valid 0",
                   tag, req_nwords, got, cmd_valid, exp_q.size());
        end
        if (exp_q.size() == 0) begin
          checks++;
          if (cyc != 1 || first_cyc >= 0) begin
            errors++;
            $display("FAIL %s empty_done: done at cycle %0d, valid seen %0d, want cycle 1, none",
                     tag, cyc, first_cyc);
          end
        end
      end else if (cmd_valid === 1'b1) begin
        if (first_cyc < 0) begin
          first_cyc = cyc;
          checks++;
          if (cyc != 1) begin
            errors++; $display("FAIL %s latency: first valid at cycle %0d want 1", tag, cyc);
          end
        end
        if (prev_hold) begin
          checks++;
          if (cmd_word !== pw || cmd_timestamp !== pt) begin
            errors++;
            $display("FAIL %s stable: word %h ts %h, want %h ts %h", tag, cmd_word, cmd_timestamp, pw, pt);
          end
        end
        if (mode == 2 && got == 1 && !stalled_once) begin
          stall = 5; stalled_once = 1'b1;
        end
        if (stall > 0) begin
          rdy = 1'b0; stall--;
        end else rdy = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        cmd_ready = rdy;
        if (rdy) begin
          checks++;
          if (got >= exp_q.size()) begin
            errors++; $display("FAIL %s extra_word: got %h, want no word", tag, cmd_word);
          end else begin
            ets = r.ts + 64'(got) * TS;
            if (cmd_word !== exp_q[got] || cmd_timestamp !== ets) begin
              errors++;
              $display("FAIL %s word%0d: got %h ts %h, want %h ts %h",
                       tag, got, cmd_word, cmd_timestamp, exp_q[got], ets);
            end
          end
          got++;
          prev_hold = 1'b0;
        end else begin
          prev_hold = 1'b1; pw = cmd_word; pt = cmd_timestamp;
        end
      end else begin
        prev_hold = 1'b0;
        cmd_ready = 1'($urandom_range(0, 1));
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s timeout: req_done not seen, got %0d words want %0d", tag, got, exp_q.size());
    end
    sh = r;
    @(posedge CLK100MHZ); #1;
    cmd_ready = 1'b0;
    checks++;
    if (req_done !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s post_done: req_done %b req_ready %b, want 0 1", tag, req_done, req_ready);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (3) @(posedge CLK100MHZ);
    #1 reset = 1'b0;
    clear_shadow();
  endtask

  function automatic req_t t4_req();
    req_t r;
    r.freq = 48'h8000_0000_0001; r.amp = 14'h1; r.phase = 14'h2;
    r.ao = 14'h3; r.to = 60'h5; r.ts = 64'hFFFF_FFFF_FFFF_FFFE; r.frc = 1'b0;
    return r;
  endfunction

  task automatic test_reset();
    apply_reset();
    checks++;
    if (req_ready !== 1'b1 || cmd_valid !== 1'b0 || cmd_word !== 64'h0 ||
        cmd_timestamp !== 64'h0 || req_done !== 1'b0 || req_nwords !== 3'd0) begin
      errors++;
      $display("FAIL reset_values: ready %b valid %b word %h ts %h done %b nwords %0d, want 1 0 0 0 0 0",
               req_ready, cmd_valid, cmd_word, cmd_timestamp, req_done, req_nwords);
    end
  endtask

  task automatic test_directed();
    req_t r;
    r = sh;
    r.freq = 48'h0000_1234_0000; r.amp = 14'h100; r.phase = 14'h0; r.ts = 64'h1000; r.frc = 1'b0;
    model_plan(r);
    checks++;
    if (exp_q.size() != 1 || exp_q[0] !== 64'h0040_0000_0000_1234) begin
      errors++; $display("FAIL t1_model: %0d words, first %h, want 1 word 0040000000001234",
                         exp_q.size(), exp_q[0]);
    end
    run_req(r, 0, "t1");
    r.ts = 64'h2000;
    run_req(r, 0, "t2_identical");
    r.freq = 48'h0000_1234_0005; r.ts = 64'h3000;
    run_req(r, 1, "t3_freq_lo");
    r.frc = 1'b1; r.ts = 64'h4000;
    run_req(r, 0, "force_refresh");
  endtask

  task automatic test_t4_t5();
    apply_reset();
    run_req(t4_req(), 0, "t4");
    apply_reset();
    run_req(t4_req(), 2, "t5_stall");
  endtask

  task automatic test_reset_mid_emit();
    req_t r;
    int got = 0;
    apply_reset();
    r = t4_req();
    model_plan(r);
    @(posedge CLK100MHZ); #1;
    drive_req(r);
    req_valid = 1'b1;
    for (int cyc = 0; cyc < 20 && got < 2; cyc++) begin
      @(posedge CLK100MHZ); #1;
      req_valid = 1'b0;
      cmd_ready = 1'b1;
      if (cmd_valid === 1'b1) begin
        checks++;
        if (cmd_word !== exp_q[got]) begin
          errors++; $display("FAIL t6_word%0d: got %h want %h", got, cmd_word, exp_q[got]);
        end
        got++;
      end
    end
    @(posedge CLK100MHZ); #1;
    cmd_ready = 1'b0;
    reset = 1'b1;
    @(posedge CLK100MHZ); #1;
    checks++;
    if (cmd_valid !== 1'b0 || cmd_word !== 64'h0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL t6_reset: valid %b word %h ready %b, want 0 0 1", cmd_valid, cmd_word, req_ready);
    end
    reset = 1'b0;
    clear_shadow();
    run_req(r, 0, "t6_reemit");
    checks++;
    if (exp_q.size() != 4) begin
      errors++; $display("FAIL t6_count: model planned %0d words want 4", exp_q.size());
    end
  endtask

  task automatic test_random();
    req_t r;
    for (int n = 0; n < 60; n++) begin
      r = sh;
      case ($urandom_range(0, 5))
        0: ;
        1: r.freq[15:0] = 16'($urandom);
        2: r.freq[47:32] = 16'($urandom);
        3: r.freq = {16'($urandom), $urandom};
        4: r.freq[47:2] = {14'($urandom), $urandom};
        default: r.freq[31:16] = 16'($urandom);
      endcase
      if ($urandom_range(0, 1) == 0) r.amp = 14'($urandom);
      if ($urandom_range(0, 1) == 0) r.phase = 14'($urandom);
      if ($urandom_range(0, 3) == 0) r.ao = 14'($urandom);
      if ($urandom_range(0, 3) == 0) r.to = {28'($urandom), $urandom};
      r.frc = ($urandom_range(0, 9) == 0);
      r.ts = {$urandom, $urandom};
      run_req(r, int'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    clear_shadow();
    test_reset();
    test_directed();
    test_t4_t5();
    test_reset_mid_emit();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
